// File: rtl/au_sequencer_pkg.sv
// rtl/au_sequencer_pkg.sv - shared FSM states, AU op codes, widths and command layout for au_sequencer
package au_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;
    localparam int CMD_W  = OP_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [OP_W-1:0] {
        AU_ADD = 2'b00,
        AU_SUB = 2'b01,
        AU_INC = 2'b10,
        AU_DEC = 2'b11
    } au_op_t;

    // FIFO entry layout {OP, B, A}
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

endpackage

// File: rtl/au_sequencer_if.sv
// rtl/au_sequencer_if.sv - command/result handshake bundle for au_sequencer; res_z exists only with AU_SEQ_ZERO_FLAG_EN
interface au_sequencer_if;
    import au_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_r;
    logic              res_c;
`ifdef AU_SEQ_ZERO_FLAG_EN
    logic              res_z;
`endif

    // Controller side: issues commands, consumes results
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
`ifdef AU_SEQ_ZERO_FLAG_EN
        input  res_z,
`endif
        input  cmd_ready, res_valid, res_r, res_c
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
`ifdef AU_SEQ_ZERO_FLAG_EN
        output res_z,
`endif
        output cmd_ready, res_valid, res_r, res_c
    );

endinterface

// File: rtl/AU.sv
// rtl/AU.sv - combinational 8-bit arithmetic unit: add, subtract, increment, decrement with carry/borrow
module AU
    import au_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_r,
    output logic              o_c
);

    logic [DATA_W:0] w_sum;

    // One extra bit holds carry out for add/inc and borrow for sub/dec
    always_comb begin
        w_sum = '0;
        case (au_op_t'(i_op))
            AU_ADD:  w_sum = {1'b0, i_a} + {1'b0, i_b};
            AU_SUB:  w_sum = {1'b0, i_a} - {1'b0, i_b};
            AU_INC:  w_sum = {1'b0, i_a} + (DATA_W+1)'(1);
            AU_DEC:  w_sum = {1'b0, i_a} - (DATA_W+1)'(1);
            default: w_sum = '0;
        endcase
    end

    assign o_r = w_sum[DATA_W-1:0];
    assign o_c = w_sum[DATA_W];

endmodule

// File: rtl/au_cmd_fifo.sv
// rtl/au_cmd_fifo.sv - show-ahead synchronous command FIFO with wrap-bit pointers and full/empty flags
module au_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same low bits: differing wrap bit means full, equal wrap bit means empty
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    // Pointer update; both advance together on simultaneous push and pop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/au_sequencer.sv
// rtl/au_sequencer.sv - queued valid/ready front end issuing commands to AU one at a time; AU_SEQ_ZERO_FLAG_EN adds res_z
module au_sequencer
    import au_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    au_sequencer_if.slave io_bus,
    output logic          o_busy
);

    logic [CMD_W-1:0]  w_fifo_rdata;
    cmd_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [DATA_W-1:0] w_au_r;
    logic              w_au_c;

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_r;
    logic              r_res_c;
`ifdef AU_SEQ_ZERO_FLAG_EN
    logic              r_res_z;
`endif

    // cmd_ready comes only from registered pointer state
    assign io_bus.cmd_ready = !w_full;
    assign w_head           = cmd_t'(w_fifo_rdata);
    assign w_pop            = (r_state == ST_IDLE) && !w_empty;
    assign o_busy           = !w_empty || (r_state != ST_IDLE);

    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_r     = r_res_r;
    assign io_bus.res_c     = r_res_c;
`ifdef AU_SEQ_ZERO_FLAG_EN
    assign io_bus.res_z     = r_res_z;
`endif

    au_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (io_bus.cmd_valid),
        .i_wdata ({io_bus.cmd_op, io_bus.cmd_b, io_bus.cmd_a}),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_empty)
    );

    AU u_au (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_r  (w_au_r),
        .o_c  (w_au_c)
    );

    // Issue FSM: pop into operand registers, capture AU output, hold until consumed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_res_valid <= 1'b0;
            r_res_r     <= '0;
            r_res_c     <= 1'b0;
`ifdef AU_SEQ_ZERO_FLAG_EN
            r_res_z     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_a     <= w_head.a;
                        r_b     <= w_head.b;
                        r_op    <= w_head.op;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_r     <= w_au_r;
                    r_res_c     <= w_au_c;
`ifdef AU_SEQ_ZERO_FLAG_EN
                    r_res_z     <= (w_au_r == '0);
`endif
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (io_bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_sequencer.sv
// tb/tb_au_sequencer.sv - randomized and directed bench for au_sequencer against a queue-based result model; honours AU_SEQ_ZERO_FLAG_EN
module tb_au_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    au_sequencer_if bus_if();

    au_sequencer #(.FIFO_DEPTH(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus_if),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_r;
    logic       prev_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: {carry_or_borrow, result}
    function automatic logic [8:0] au_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int s;
        case (op)
            2'd0:    s = int'(a) + int'(b);
            2'd1:    s = int'(a) - int'(b);
            2'd2:    s = int'(a) + 1;
            default: s = int'(a) - 1;
        endcase
        return {((s < 0) || (s > 255)), 8'(s & 255)};
    endfunction

    // Scoreboard: sees what will be sampled at the coming rising edge
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(bus_if.res_valid), 32'd1);
                check("hold_r", 32'(bus_if.res_r), 32'(prev_r));
                check("hold_c", 32'(bus_if.res_c), 32'(prev_c));
            end
            if (bus_if.res_valid && bus_if.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_r", 32'(bus_if.res_r), 32'(mon_e[7:0]));
                    check("res_c", 32'(bus_if.res_c), 32'(mon_e[8]));
`ifdef AU_SEQ_ZERO_FLAG_EN
                    check("res_z", 32'(bus_if.res_z), 32'(mon_e[7:0] == 8'd0));
`endif
                end
            end
            if (bus_if.cmd_valid && bus_if.cmd_ready)
                exp_q.push_back(au_ref(bus_if.cmd_a, bus_if.cmd_b, bus_if.cmd_op));
            prev_hold = bus_if.res_valid && !bus_if.res_ready;
            prev_r    = bus_if.res_r;
            prev_c    = bus_if.res_c;
        end
    end

    // Single command into an idle block; valid must rise exactly three edges after accept
    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] er, input logic ec);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        bus_if.cmd_op    = op;
        bus_if.res_ready = 1'b1;
        #2 check({tag, "_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        #2 check({tag, "_lat1"}, 32'(bus_if.res_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        #2 check({tag, "_lat2"}, 32'(bus_if.res_valid), 32'd0);
        @(negedge clk);
        #2 check({tag, "_lat3"}, 32'(bus_if.res_valid), 32'd1);
        check({tag, "_r"}, 32'(bus_if.res_r), 32'(er));
        check({tag, "_c"}, 32'(bus_if.res_c), 32'(ec));
`ifdef AU_SEQ_ZERO_FLAG_EN
        check({tag, "_z"}, 32'(bus_if.res_z), 32'(er == 8'd0));
`endif
        @(negedge clk);
        #2 check({tag, "_cleared"}, 32'(bus_if.res_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.res_ready = 1'b1;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        #2 check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] got [3];
        int         cnt;
        int         idx;
        int         w;

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_a     = '0;
        bus_if.cmd_b     = '0;
        bus_if.cmd_op    = '0;
        bus_if.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2 check("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        check("rst_res_r", 32'(bus_if.res_r), 32'd0);
        check("rst_res_c", 32'(bus_if.res_c), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
`ifdef AU_SEQ_ZERO_FLAG_EN
        check("rst_res_z", 32'(bus_if.res_z), 32'd0);
`endif

        single("add", 8'h02, 8'h01, 2'b00, 8'h03, 1'b0);
        single("ovf", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);

        // Burst under backpressure
        @(negedge clk);
        bus_if.res_ready = 1'b0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_a = 8'd8; bus_if.cmd_b = 8'd1; bus_if.cmd_op = 2'b01;
        @(negedge clk);
        bus_if.cmd_a = 8'd4; bus_if.cmd_b = 8'd0; bus_if.cmd_op = 2'b10;
        @(negedge clk);
        bus_if.cmd_a = 8'd1; bus_if.cmd_b = 8'd0; bus_if.cmd_op = 2'b11;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2 check("burst_hold_valid", 32'(bus_if.res_valid), 32'd1);
            check("burst_hold_r", 32'(bus_if.res_r), 32'h07);
        end
        cnt = 0;
        got[0] = 8'hxx; got[1] = 8'hxx; got[2] = 8'hxx;
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            @(negedge clk);
            bus_if.res_ready = 1'b1;
            #2;
            if (bus_if.res_valid) begin
                got[cnt] = bus_if.res_r;
                cnt++;
            end
        end
        check("burst_count", 32'(cnt), 32'd3);
        check("burst_r0", 32'(got[0]), 32'h07);
        check("burst_r1", 32'(got[1]), 32'h05);
        check("burst_r2", 32'(got[2]), 32'h00);
        drain("burst_drain");

        // Fill the FIFO: 4 queued plus 1 in flight, sixth refused
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_if.res_ready = 1'b0;
            if (idx < 6) begin
                bus_if.cmd_valid = 1'b1;
                bus_if.cmd_a     = 8'(idx * 37 + 5);
                bus_if.cmd_b     = 8'(idx * 11 + 1);
                bus_if.cmd_op    = 2'(idx);
            end else begin
                bus_if.cmd_valid = 1'b0;
            end
            #2;
            if (bus_if.cmd_valid && bus_if.cmd_ready) idx++;
        end
        check("full_accepted", 32'(idx), 32'd5);
        check("full_ready_low", 32'(bus_if.cmd_ready), 32'd0);
        drain("full_drain");

        // Reset while EXEC holds a command and two remain queued
        @(negedge clk);
        bus_if.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_a     = 8'($urandom);
            bus_if.cmd_b     = 8'($urandom);
            bus_if.cmd_op    = 2'($urandom);
        end
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        #2;
        w = 0;
        while (!bus_if.res_valid && w < 20) begin
            @(negedge clk);
            #2;
            w++;
        end
        check("rstmid_first_valid", 32'(bus_if.res_valid), 32'd1);
        @(negedge clk);
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2 check("rstmid_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #2 check("rstmid_res_valid", 32'(bus_if.res_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_if.res_ready = 1'b1;
            #2 check("rstmid_no_stale", 32'(bus_if.res_valid), 32'd0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst              = ($urandom_range(0, 249) == 0);
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd_a     = 8'($urandom);
            bus_if.cmd_b     = 8'($urandom);
            bus_if.cmd_op    = 2'($urandom);
            bus_if.res_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst = 1'b0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
